// File: rtl/tawas_slice_sched_pkg.sv
// ============================================================================
//  tawas_sched_pkg
//  Shared slice-state encodings, error codes and helpers for the Tawas
//  per-slice load/store scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package tawas_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LWAIT = 2'd1,
        ST_FENCE = 2'd2
    } slice_st_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UDF  = 2'd2;

    // Index of the lowest set bit (0 when none set).
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tawas_slice_sched_if.sv
// ============================================================================
//  tawas_slice_sched_if
//  LS-issue / RCN-response / fetch-stall bundle of the slice scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface tawas_slice_sched_if #(
    parameter int CNT_W = 3
);
    logic               req_vld;
    logic [1:0]         req_slice;
    logic               req_load;
    logic               fence_vld;
    logic [1:0]         fence_slice;
    logic               rsp_vld;
    logic [1:0]         rsp_slice;
    logic [3:0]         rcn_stall;
    logic [4*CNT_W-1:0] outst_cnt;
    logic               err_vld;
    logic [1:0]         err_slice;
    logic               timeout;

    modport master (
        output req_vld, req_slice, req_load, fence_vld, fence_slice,
               rsp_vld, rsp_slice,
        input  rcn_stall, outst_cnt, err_vld, err_slice, timeout
    );

    modport slave (
        input  req_vld, req_slice, req_load, fence_vld, fence_slice,
               rsp_vld, rsp_slice,
        output rcn_stall, outst_cnt, err_vld, err_slice, timeout
    );
endinterface

`default_nettype wire

// File: rtl/tawas_slice_track.sv
// ============================================================================
//  tawas_slice_track
//  Outstanding-transaction counter and RUN/LWAIT/FENCE sequencer for one slice.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tawas_slice_track
    import tawas_sched_pkg::*;
#(
    parameter int MAX_OUTST = 3,
    parameter int CNT_W     = 3
`ifdef TAWAS_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 1023
`endif
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             req,
    input  wire logic             load,
    input  wire logic             rsp,
    input  wire logic             fence,
`ifdef TAWAS_SCHED_TIMEOUT_EN
    input  wire logic             exp_grant,
    output logic                  exp_req,
`endif
    output logic                  stall,
    output logic [CNT_W-1:0]      cnt,
    output logic                  ovf,
    output logic                  udf
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_OUTST);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pos;
    slice_st_t        r_st;

    logic             w_req_acc;
    logic             w_rsp_acc;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign ovf       = req && (r_cnt == c_max) && !rsp;
    assign udf       = rsp && (r_cnt == '0);
    assign w_req_acc = req && !ovf;
    assign w_rsp_acc = rsp && !udf;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_req_acc, w_rsp_acc})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_pos <= '0;
            r_st  <= ST_RUN;
        end else
`ifdef TAWAS_SCHED_TIMEOUT_EN
        if (exp_grant) begin
            r_cnt <= '0;
            r_pos <= '0;
            r_st  <= ST_RUN;
        end else
`endif
        begin
            r_cnt <= w_cnt_nxt;
            case (r_st)
                ST_RUN: begin
                    // A same-cycle response retires one older entry ahead of the load.
                    if (w_req_acc && load) begin
                        r_st  <= ST_LWAIT;
                        r_pos <= r_cnt - CNT_W'(w_rsp_acc);
                    end else if (fence && !(req && load) && (w_cnt_nxt != '0)) begin
                        r_st  <= ST_FENCE;
                    end
                end
                ST_LWAIT: begin
                    if (w_rsp_acc) begin
                        if (r_pos == '0) r_st <= ST_RUN;
                        else             r_pos <= r_pos - 1'b1;
                    end
                end
                ST_FENCE: begin
                    if (w_cnt_nxt == '0) r_st <= ST_RUN;
                end
                default: r_st <= ST_RUN;
            endcase
        end
    end

`ifdef TAWAS_SCHED_TIMEOUT_EN
    localparam int             WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] c_wd_lim = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd;

    // Saturates one short of TIMEOUT so recovery lands on the TIMEOUT-th edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (exp_grant || (r_st == ST_RUN)) begin
            r_wd <= '0;
        end else if (r_wd != c_wd_lim) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign exp_req = (r_st != ST_RUN) && (r_wd == c_wd_lim);
`endif

    assign stall = (r_st != ST_RUN) || (r_cnt == c_max);
    assign cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/tawas_slice_sched.sv
// ============================================================================
//  tawas_slice_sched
//  Four-slice RCN load/store sequencer driving the fetch stall vector.
//  Optional watchdog recovery: define TAWAS_SCHED_TIMEOUT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tawas_slice_sched
    import tawas_sched_pkg::*;
#(
    parameter int MAX_OUTST = 3,
    parameter int CNT_W     = 3,
    parameter int TIMEOUT   = 1023
) (
    input  wire logic            clk,
    input  wire logic            rst,
    tawas_slice_sched_if.slave   bus
);

    if ((MAX_OUTST < 1) || (MAX_OUTST > 7) || (MAX_OUTST >= (1 << CNT_W)) ||
        (TIMEOUT < 1)) begin : g_bad_param
        $error("tawas_slice_sched: illegal MAX_OUTST/CNT_W/TIMEOUT");
    end

    logic [3:0]         w_req;
    logic [3:0]         w_rsp;
    logic [3:0]         w_fence;
    logic [3:0]         w_stall;
    logic [3:0]         w_ovf;
    logic [3:0]         w_udf;
    logic [4*CNT_W-1:0] w_cnt_flat;
    logic [1:0]         w_err_code;

    logic               r_err_vld;
    logic [1:0]         r_err_slice;

`ifdef TAWAS_SCHED_TIMEOUT_EN
    logic [3:0]         w_exp_req;
    logic [3:0]         w_exp_gnt;
    logic               r_timeout;

    // Lowest requesting slice recovers now; the rest hold and go next cycle.
    assign w_exp_gnt = w_exp_req & (~w_exp_req + 4'd1);
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign w_req[gi]   = bus.req_vld   && (bus.req_slice   == 2'(gi));
        assign w_rsp[gi]   = bus.rsp_vld   && (bus.rsp_slice   == 2'(gi));
        assign w_fence[gi] = bus.fence_vld && (bus.fence_slice == 2'(gi));

        tawas_slice_track #(
            .MAX_OUTST (MAX_OUTST),
            .CNT_W     (CNT_W)
`ifdef TAWAS_SCHED_TIMEOUT_EN
            ,
            .TIMEOUT   (TIMEOUT)
`endif
        ) u_track (
            .clk       (clk),
            .rst       (rst),
            .req       (w_req[gi]),
            .load      (bus.req_load),
            .rsp       (w_rsp[gi]),
            .fence     (w_fence[gi]),
`ifdef TAWAS_SCHED_TIMEOUT_EN
            .exp_grant (w_exp_gnt[gi]),
            .exp_req   (w_exp_req[gi]),
`endif
            .stall     (w_stall[gi]),
            .cnt       (w_cnt_flat[gi*CNT_W +: CNT_W]),
            .ovf       (w_ovf[gi]),
            .udf       (w_udf[gi])
        );
    end

    // Only one request and one response per cycle, so each error type names one slice.
    always_comb begin
        w_err_code = ERR_NONE;
        if (|w_ovf)      w_err_code = ERR_OVF;
        else if (|w_udf) w_err_code = ERR_UDF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_vld   <= 1'b0;
            r_err_slice <= 2'd0;
`ifdef TAWAS_SCHED_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_err_vld <= (w_err_code != ERR_NONE);
            case (w_err_code)
                ERR_OVF: r_err_slice <= bus.req_slice;
                ERR_UDF: r_err_slice <= bus.rsp_slice;
                default: begin
`ifdef TAWAS_SCHED_TIMEOUT_EN
                    if (|w_exp_req) r_err_slice <= lowest_idx(w_exp_req);
`endif
                end
            endcase
`ifdef TAWAS_SCHED_TIMEOUT_EN
            r_timeout <= |w_exp_req;
`endif
        end
    end

    assign bus.rcn_stall = w_stall;
    assign bus.outst_cnt = w_cnt_flat;
    assign bus.err_vld   = r_err_vld;
    assign bus.err_slice = r_err_slice;
`ifdef TAWAS_SCHED_TIMEOUT_EN
    assign bus.timeout   = r_timeout;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tawas_slice_sched.sv
// ============================================================================
//  tb_tawas_slice_sched
//  Directed plus random stimulus against a queue-based slice model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tawas_slice_sched;

    localparam int MAX = 3;
    localparam int CW  = 3;
    localparam int TO  = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tawas_slice_sched_if #(.CNT_W(CW)) bus ();

    tawas_slice_sched #(
        .MAX_OUTST (MAX),
        .CNT_W     (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: each slice keeps its outstanding entries in issue order. An entry
    // of 1 is the load the slice is waiting on; a slice is blocked while that
    // load is outstanding, or while a fence is pending and entries remain.
    int         q[4][$];
    bit         m_wait[4];
    bit         m_fence[4];
    bit         m_err;
    logic [1:0] m_err_slice;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            q[s].delete();
            m_wait[s]  = 1'b0;
            m_fence[s] = 1'b0;
        end
        m_err       = 1'b0;
        m_err_slice = 2'd0;
    endtask

    task automatic model_step(input bit rv, input logic [1:0] rs, input bit rl,
                              input bit fv, input logic [1:0] fs,
                              input bit pv, input logic [1:0] ps);
        bit ovf_any, udf_any;
        bit rq, rp, fc, was_run, o, u;
        int popped;
        ovf_any = 1'b0;
        udf_any = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rq      = rv && (rs == 2'(s));
            rp      = pv && (ps == 2'(s));
            fc      = fv && (fs == 2'(s)) && !(rq && rl);
            was_run = !m_wait[s] && !m_fence[s];
            o       = rq && (q[s].size() == MAX) && !rp;
            u       = rp && (q[s].size() == 0);
            popped  = 0;
            if (rp && !u) popped = q[s].pop_front();
            if (rq && !o) q[s].push_back((was_run && rl) ? 1 : 0);
            if (was_run) begin
                if (rq && !o && rl)             m_wait[s]  = 1'b1;
                else if (fc && q[s].size() != 0) m_fence[s] = 1'b1;
            end else begin
                if (m_wait[s] && popped == 1)   m_wait[s]  = 1'b0;
                if (m_fence[s] && q[s].size() == 0) m_fence[s] = 1'b0;
            end
            ovf_any |= o;
            udf_any |= u;
        end
        m_err = ovf_any || udf_any;
        if (ovf_any)      m_err_slice = rs;
        else if (udf_any) m_err_slice = ps;
    endtask

    task automatic check_all(input string tag);
        logic [3:0]      e_stall;
        logic [4*CW-1:0] e_cnt;
        for (int s = 0; s < 4; s++) begin
            e_stall[s]           = m_wait[s] || m_fence[s] || (q[s].size() == MAX);
            e_cnt[s*CW +: CW]    = CW'(q[s].size());
        end
        chk({tag, ".stall"},     32'(bus.rcn_stall), 32'(e_stall));
        chk({tag, ".cnt"},       32'(bus.outst_cnt), 32'(e_cnt));
        chk({tag, ".err_vld"},   32'(bus.err_vld),   32'(m_err));
        chk({tag, ".err_slice"}, 32'(bus.err_slice), 32'(m_err_slice));
        chk({tag, ".timeout"},   32'(bus.timeout),   32'd0);
    endtask

    task automatic drive(input bit rv, input logic [1:0] rs, input bit rl,
                         input bit fv, input logic [1:0] fs,
                         input bit pv, input logic [1:0] ps);
        bus.req_vld     = rv;
        bus.req_slice   = rs;
        bus.req_load    = rl;
        bus.fence_vld   = fv;
        bus.fence_slice = fs;
        bus.rsp_vld     = pv;
        bus.rsp_slice   = ps;
    endtask

    task automatic cyc(input string tag, input bit rv, input logic [1:0] rs, input bit rl,
                       input bit fv, input logic [1:0] fs,
                       input bit pv, input logic [1:0] ps);
        drive(rv, rs, rl, fv, fs, pv, ps);
        @(posedge clk);
        #1;
        model_step(rv, rs, rl, fv, fs, pv, ps);
        check_all(tag);
    endtask

    task automatic store(input logic [1:0] s); cyc("store", 1, s, 0, 0, 0, 0, 0); endtask
    task automatic ld(input logic [1:0] s);    cyc("load",  1, s, 1, 0, 0, 0, 0); endtask
    task automatic rsp(input logic [1:0] s);   cyc("rsp",   0, 0, 0, 0, 0, 1, s); endtask
    task automatic idle();                     cyc("idle",  0, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Store burst on slice 1.
        store(1); store(1); store(1);
        chk("burst_stall", 32'(bus.rcn_stall), 32'h2);
        rsp(1);
        chk("burst_release", 32'(bus.rcn_stall), 32'h0);
        chk("burst_cnt1", 32'(bus.outst_cnt[5:3]), 32'd2);
        rsp(1); rsp(1);

        // In-order load behind two stores on slice 2.
        store(2); store(2); ld(2);
        chk("load_stall", 32'(bus.rcn_stall), 32'h4);
        rsp(2); rsp(2);
        chk("load_hold", 32'(bus.rcn_stall), 32'h4);
        rsp(2);
        chk("load_release", 32'(bus.rcn_stall), 32'h0);
        chk("load_cnt2", 32'(bus.outst_cnt[8:6]), 32'd0);

        // Fence on slice 0, then fence with nothing outstanding.
        store(0); store(0);
        cyc("fence", 0, 0, 0, 1, 0, 0, 0);
        chk("fence_stall", 32'(bus.rcn_stall), 32'h1);
        rsp(0);
        chk("fence_hold", 32'(bus.rcn_stall), 32'h1);
        rsp(0);
        chk("fence_release", 32'(bus.rcn_stall), 32'h0);
        cyc("fence_empty", 0, 0, 0, 1, 0, 0, 0);
        chk("fence_empty_stall", 32'(bus.rcn_stall), 32'h0);

        // Fence and load together: load wins.
        cyc("fence_load", 1, 0, 1, 1, 0, 0, 0);
        rsp(0);

        // Full slice 3: simultaneous request and response, then underflow.
        store(3); store(3); store(3);
        cyc("req_rsp_full", 1, 3, 0, 0, 0, 1, 3);
        chk("req_rsp_no_err", 32'(bus.err_vld), 32'd0);
        chk("req_rsp_cnt3", 32'(bus.outst_cnt[11:9]), 32'd3);
        store(3);
        chk("overflow_err", 32'(bus.err_vld), 32'd1);
        rsp(3); rsp(3); rsp(3);
        rsp(3);
        chk("underflow_err", 32'(bus.err_vld), 32'd1);
        chk("underflow_slice", 32'(bus.err_slice), 32'd3);

        // Independent slices, responses returned 3,0,2,1.
        ld(0); ld(1); ld(2); ld(3);
        chk("indep_all", 32'(bus.rcn_stall), 32'hF);
        rsp(3); chk("indep_r3", 32'(bus.rcn_stall), 32'h7);
        rsp(0); chk("indep_r0", 32'(bus.rcn_stall), 32'h6);
        rsp(2); chk("indep_r2", 32'(bus.rcn_stall), 32'h2);
        rsp(1); chk("indep_r1", 32'(bus.rcn_stall), 32'h0);

`ifdef TAWAS_SCHED_TIMEOUT_EN
        begin
            int hit;
            hit = 0;
            ld(1);
            drive(0, 0, 0, 0, 0, 0, 0);
            for (int i = 1; i <= 3 * TO; i++) begin
                @(posedge clk);
                #1;
                if (bus.timeout === 1'b1) begin
                    hit = i;
                    break;
                end
            end
            chk("timeout_cycle", 32'(hit), 32'(TO));
            chk("timeout_stall", 32'(bus.rcn_stall), 32'h0);
            chk("timeout_cnt", 32'(bus.outst_cnt), 32'h0);
            chk("timeout_slice", 32'(bus.err_slice), 32'd1);
            q[1].delete();
            m_wait[1]   = 1'b0;
            m_err       = 1'b0;
            m_err_slice = 2'd1;
            idle();
        end
`else
        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                ld(2); store(1);
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all("mid_reset");
                #2 rst = 1'b0;
                rsp(2);
                chk("stale_rsp_err", 32'(bus.err_vld), 32'd1);
                chk("stale_rsp_slice", 32'(bus.err_slice), 32'd2);
            end
            cyc("rand",
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
